// File: rtl/i2c_master.sv
// Single-byte I2C master: START, addr+R/W, ACK, one data byte, ACK, STOP per command.
// SCL is push-pull; SDA is open-drain and only ever driven low or released.
module i2c_master #(
  parameter int unsigned CLK_DIV = 250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] tx_data,
  output logic [7:0] rx_data,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       SCL,
  inout  wire        SDA
);

  localparam int unsigned QW = $clog2(CLK_DIV);
  localparam logic [QW-1:0] QLast = QW'(CLK_DIV - 1);

  typedef enum logic [3:0] {
    StIdle,
    StStart,
    StAddr,
    StAddrAck,
    StWrData,
    StWrAck,
    StRdData,
    StRdAck,
    StStop
  } state_e;

  state_e          state_q, state_d;
  logic [QW-1:0]   q_cnt_q, q_cnt_d;
  logic [1:0]      phase_q, phase_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      addr_byte_q, addr_byte_d;
  logic [7:0]      tx_q, tx_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            sample_q, sample_d;
  logic            nack_q, nack_d;
  logic            ack_err_q, ack_err_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            scl_q, scl_d;
  logic            sda_low_q, sda_low_d;

  logic q_last, bit_end, sample_pt, sda_in, cur_bit;

  assign sda_in    = SDA;
  assign SDA       = sda_low_q ? 1'b0 : 1'bz;
  assign q_last    = (q_cnt_q == QLast);
  assign bit_end   = (state_q != StIdle) && q_last && (phase_q == 2'd3);
  assign sample_pt = (state_q != StIdle) && q_last && (phase_q == 2'd2);

  always_comb begin
    state_d     = state_q;
    q_cnt_d     = q_cnt_q;
    phase_d     = phase_q;
    bit_cnt_d   = bit_cnt_q;
    addr_byte_d = addr_byte_q;
    tx_d        = tx_q;
    rx_shift_d  = rx_shift_q;
    rx_data_d   = rx_data_q;
    sample_d    = sample_q;
    nack_d      = nack_q;
    ack_err_d   = ack_err_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    cur_bit     = 1'b1;
    scl_d       = 1'b1;
    sda_low_d   = 1'b0;

    if (state_q != StIdle) begin
      if (q_last) begin
        q_cnt_d = '0;
        phase_d = phase_q + 2'd1;
      end else begin
        q_cnt_d = q_cnt_q + QW'(1);
      end
    end

    if (sample_pt) begin
      sample_d = sda_in;
      if (state_q == StRdData) begin
        rx_shift_d = {rx_shift_q[6:0], sda_in};
        if (bit_cnt_q == 3'd7) rx_data_d = {rx_shift_q[6:0], sda_in};
      end
    end

    unique case (state_q)
      StIdle: begin
        // A start coinciding with the done pulse is dropped.
        if (start && !done_q) begin
          state_d     = StStart;
          addr_byte_d = {addr, rw};
          tx_d        = tx_data;
          ack_err_d   = 1'b0;
          nack_d      = 1'b0;
          busy_d      = 1'b1;
          q_cnt_d     = '0;
          phase_d     = 2'd0;
        end
      end
      StStart: if (bit_end) begin
        state_d   = StAddr;
        bit_cnt_d = 3'd0;
      end
      StAddr: if (bit_end) begin
        if (bit_cnt_q == 3'd7) state_d = StAddrAck;
        else bit_cnt_d = bit_cnt_q + 3'd1;
      end
      StAddrAck: if (bit_end) begin
        bit_cnt_d = 3'd0;
        if (sample_q) begin
          nack_d  = 1'b1;
          state_d = StStop;
        end else begin
          state_d = addr_byte_q[0] ? StRdData : StWrData;
        end
      end
      StWrData: if (bit_end) begin
        if (bit_cnt_q == 3'd7) state_d = StWrAck;
        else bit_cnt_d = bit_cnt_q + 3'd1;
      end
      StWrAck: if (bit_end) begin
        if (sample_q) nack_d = 1'b1;
        state_d = StStop;
      end
      StRdData: if (bit_end) begin
        if (bit_cnt_q == 3'd7) state_d = StRdAck;
        else bit_cnt_d = bit_cnt_q + 3'd1;
      end
      StRdAck: if (bit_end) state_d = StStop;
      StStop: if (bit_end) begin
        state_d   = StIdle;
        done_d    = 1'b1;
        busy_d    = 1'b0;
        ack_err_d = nack_q;
      end
      default: state_d = StIdle;
    endcase

    // Pin levels are derived from the upcoming state so they register in step with it.
    if (state_d == StAddr) cur_bit = addr_byte_d[3'd7 - bit_cnt_d];
    if (state_d == StWrData) cur_bit = tx_d[3'd7 - bit_cnt_d];

    unique case (state_d)
      StIdle: begin
        scl_d     = 1'b1;
        sda_low_d = 1'b0;
      end
      StStart: begin
        scl_d     = (phase_d != 2'd3);
        sda_low_d = phase_d[1];
      end
      StAddr, StWrData: begin
        scl_d     = phase_d[1];
        sda_low_d = !cur_bit;
      end
      StAddrAck, StWrAck, StRdData: begin
        scl_d     = phase_d[1];
        sda_low_d = 1'b0;
      end
      StRdAck: begin
        scl_d     = phase_d[1];
        sda_low_d = 1'b1;
      end
      StStop: begin
        scl_d     = phase_d[1];
        sda_low_d = (phase_d != 2'd3);
      end
      default: begin
        scl_d     = 1'b1;
        sda_low_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      q_cnt_q     <= '0;
      phase_q     <= 2'd0;
      bit_cnt_q   <= 3'd0;
      addr_byte_q <= 8'h00;
      tx_q        <= 8'h00;
      rx_shift_q  <= 8'h00;
      rx_data_q   <= 8'h00;
      sample_q    <= 1'b1;
      nack_q      <= 1'b0;
      ack_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      scl_q       <= 1'b1;
      sda_low_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      q_cnt_q     <= q_cnt_d;
      phase_q     <= phase_d;
      bit_cnt_q   <= bit_cnt_d;
      addr_byte_q <= addr_byte_d;
      tx_q        <= tx_d;
      rx_shift_q  <= rx_shift_d;
      rx_data_q   <= rx_data_d;
      sample_q    <= sample_d;
      nack_q      <= nack_d;
      ack_err_q   <= ack_err_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      scl_q       <= scl_d;
      sda_low_q   <= sda_low_d;
    end
  end

  assign rx_data = rx_data_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign ack_err = ack_err_q;
  assign SCL     = scl_q;

endmodule

// File: tb/tb_i2c_master.sv
// Bench for i2c_master: slave model at 7'h55 on a pulled-up bus, a frame-level timing
// model compared every cycle, a bus protocol monitor, and a CLK_DIV=250 address-NACK frame.
module tb_i2c_master;

  localparam int D1 = 4;
  localparam int D2 = 250;
  localparam logic [6:0] SLAVE_ADDR = 7'h55;

  localparam int SL_IDLE = 0, SL_ADDR = 1, SL_AACK = 2, SL_WR = 3;
  localparam int SL_WACK = 4, SL_RD = 5, SL_RACK = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       start2 = 1'b0;
  logic       rw = 1'b0;
  logic [6:0] addr = 7'h00;
  logic [7:0] tx = 8'h00;

  logic [7:0] rx_data, rx2;
  logic       busy, done, ack_err, scl;
  logic       busy2, done2, ack2, scl2;
  wire        sda;
  wire        sda2;
  logic       sda_s;
  logic       sl_low = 1'b0;

  pullup (sda);
  pullup (sda2);
  assign sda   = sl_low ? 1'b0 : 1'bz;
  assign sda_s = (sda === 1'b0) ? 1'b0 : 1'b1;

  always #5 clk = ~clk;

  i2c_master #(.CLK_DIV(D1)) dut (
    .clk(clk), .reset(rst), .start(start), .rw(rw), .addr(addr), .tx_data(tx),
    .rx_data(rx_data), .busy(busy), .done(done), .ack_err(ack_err), .SCL(scl), .SDA(sda)
  );

  i2c_master #(.CLK_DIV(D2)) dut2 (
    .clk(clk), .reset(rst), .start(start2), .rw(rw), .addr(addr), .tx_data(tx),
    .rx_data(rx2), .busy(busy2), .done(done2), .ack_err(ack2), .SCL(scl2), .SDA(sda2)
  );

  // Slave model: one 8-bit register at SLAVE_ADDR, decoded from bus edges.
  logic       ps_scl = 1'b1, ps_sda = 1'b1;
  int         sl_st = SL_IDLE, sl_cnt = 0;
  logic [7:0] sl_sh = 8'h00, sl_led = 8'h00, sl_addr_seen = 8'h00;
  logic       sl_mack = 1'b1;

  always @(negedge clk) begin
    ps_scl <= scl;
    ps_sda <= sda_s;
    if (ps_scl && scl && ps_sda && !sda_s) begin
      sl_st  <= SL_ADDR;
      sl_cnt <= 0;
    end else if (ps_scl && scl && !ps_sda && sda_s) begin
      sl_st  <= SL_IDLE;
      sl_low <= 1'b0;
    end else begin
      case (sl_st)
        SL_ADDR, SL_WR: begin
          if (!ps_scl && scl) begin
            sl_sh  <= {sl_sh[6:0], sda_s};
            sl_cnt <= sl_cnt + 1;
          end else if (ps_scl && !scl && sl_cnt == 8) begin
            if (sl_st == SL_WR) begin
              sl_led <= sl_sh;
              sl_low <= 1'b1;
              sl_st  <= SL_WACK;
            end else begin
              sl_addr_seen <= sl_sh;
              if (sl_sh[7:1] == SLAVE_ADDR) begin
                sl_low <= 1'b1;
                sl_st  <= SL_AACK;
              end else begin
                sl_st <= SL_IDLE;
              end
            end
          end
        end
        SL_AACK: if (ps_scl && !scl) begin
          sl_cnt <= 0;
          if (sl_sh[0]) begin
            sl_st  <= SL_RD;
            sl_low <= !sl_led[7];
          end else begin
            sl_st  <= SL_WR;
            sl_low <= 1'b0;
          end
        end
        SL_WACK: if (ps_scl && !scl) begin
          sl_low <= 1'b0;
          sl_st  <= SL_IDLE;
        end
        SL_RD: if (ps_scl && !scl) begin
          if (sl_cnt == 7) begin
            sl_low <= 1'b0;
            sl_st  <= SL_RACK;
          end else begin
            sl_low <= !sl_led[6 - sl_cnt];
          end
          sl_cnt <= sl_cnt + 1;
        end
        SL_RACK: if (!ps_scl && scl) begin
          sl_mack <= sda_s;
          if (!sda_s) sl_st <= SL_IDLE;
        end
        default: ;
      endcase
    end
  end

  // Protocol monitor: counts SDA falls/rises while SCL stays high.
  logic pc_scl = 1'b1, pc_sda = 1'b1, pc_rst = 1'b1;
  int   n_sedge = 0, n_pedge = 0;

  always @(negedge clk) begin
    pc_scl <= scl;
    pc_sda <= sda_s;
    pc_rst <= rst;
    if (!rst && !pc_rst && pc_scl && scl && (sda_s != pc_sda)) begin
      if (!sda_s) n_sedge <= n_sedge + 1;
      else n_pedge <= n_pedge + 1;
    end
  end

  // Frame-level model: a frame lasts (bit periods * 4 * CLK_DIV) cycles after acceptance.
  logic       m_busy = 1'b0, m_done = 1'b0, m_ack_err = 1'b0;
  logic [7:0] m_rx = 8'h00, m_led = 8'h00, m_p_data = 8'h00;
  logic       m_p_err = 1'b0, m_p_wr = 1'b0, m_p_rd = 1'b0;
  int         m_rem = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy    <= 1'b0;
      m_done    <= 1'b0;
      m_ack_err <= 1'b0;
      m_rx      <= 8'h00;
      m_rem     <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        m_rem <= m_rem - 1;
        if (m_rem == 1) begin
          m_busy    <= 1'b0;
          m_done    <= 1'b1;
          m_ack_err <= m_p_err;
          if (m_p_wr) m_led <= m_p_data;
          if (m_p_rd) m_rx <= m_led;
        end
      end else if (start && !m_done) begin
        m_busy    <= 1'b1;
        m_ack_err <= 1'b0;
        m_rem     <= ((addr == SLAVE_ADDR) ? 20 : 11) * 4 * D1;
        m_p_err   <= (addr != SLAVE_ADDR);
        m_p_wr    <= (addr == SLAVE_ADDR) && !rw;
        m_p_rd    <= (addr == SLAVE_ADDR) && rw;
        m_p_data  <= tx;
      end
    end
  end

  int n_checks = 0;
  int n_errors = 0;
  int e_s0 = 0, e_p0 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [6:0] a, input logic r, input logic [7:0] d);
    addr  = a;
    rw    = r;
    tx    = d;
    start = 1'b1;
    e_s0  = n_sedge;
    e_p0  = n_pedge;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int dt);
    dt = 0;
    while (!done && dt < budget) begin
      tick();
      dt++;
    end
    if (!done) begin
      n_checks++;
      n_errors++;
      $display("FAIL done_timeout: no done within %0d cycles", budget);
    end
  endtask

  task automatic frame_edges(input string tag);
    chk({tag, "_start_edges"}, n_sedge - e_s0, 1);
    chk({tag, "_stop_edges"}, n_pedge - e_p0, 1);
  endtask

  initial begin
    int dt;
    int ndone;
    int first_i;

    fork
      forever begin
        @(negedge clk);
        if (!rst) begin
          chk("cyc_ctrl", {29'b0, busy, done, ack_err}, {29'b0, m_busy, m_done, m_ack_err});
          if (!m_busy) chk("cyc_rx", {24'b0, rx_data}, {24'b0, m_rx});
        end
      end
    join_none

    // Reset state
    repeat (3) tick();
    chk("rst_scl", {31'b0, scl}, 1);
    chk("rst_sda", {31'b0, sda_s}, 1);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_ack_err", {31'b0, ack_err}, 0);
    chk("rst_rx", {24'b0, rx_data}, 8'h00);
    chk("rst_scl2", {31'b0, scl2}, 1);
    rst = 1'b0;
    repeat (3) tick();

    // Write 8'hA5 to the slave; 20 bit periods
    launch(7'h55, 1'b0, 8'hA5);
    chk("wr_busy", {31'b0, busy}, 1);
    wait_done(1000, dt);
    chk("wr_done_cycle", dt, 80 * D1);
    chk("wr_ack_err", {31'b0, ack_err}, 0);
    chk("wr_led", {24'b0, sl_led}, 8'hA5);
    chk("wr_addr_byte", {24'b0, sl_addr_seen}, 8'hAA);
    frame_edges("wr");
    repeat (5) tick();

    // Read it back
    launch(7'h55, 1'b1, 8'h00);
    wait_done(1000, dt);
    chk("rd_done_cycle", dt, 80 * D1);
    chk("rd_rx", {24'b0, rx_data}, 8'hA5);
    chk("rd_ack_err", {31'b0, ack_err}, 0);
    chk("rd_addr_byte", {24'b0, sl_addr_seen}, 8'hAB);
    chk("rd_master_ack", {31'b0, sl_mack}, 0);
    frame_edges("rd");
    repeat (5) tick();
    chk("rd_slave_idle", sl_st, SL_IDLE);

    // Wrong address: NACK, STOP after 11 bit periods
    launch(7'h12, 1'b0, 8'h3C);
    wait_done(1000, dt);
    chk("nack_done_cycle", dt, 44 * D1);
    chk("nack_ack_err", {31'b0, ack_err}, 1);
    chk("nack_rx", {24'b0, rx_data}, 8'hA5);
    chk("nack_led", {24'b0, sl_led}, 8'hA5);
    frame_edges("nack");
    repeat (5) tick();

    // Starts while busy and in the done cycle are ignored
    launch(7'h55, 1'b0, 8'h5A);
    tx      = 8'h77;
    ndone   = 0;
    first_i = -1;
    for (int i = 1; i <= 400; i++) begin
      tick();
      if (done) begin
        ndone++;
        if (first_i < 0) first_i = i;
      end
      start = done || (i == 49);
    end
    start = 1'b0;
    chk("busy_ign_ndone", ndone, 1);
    chk("busy_ign_cycle", first_i, 80 * D1);
    chk("busy_ign_busy", {31'b0, busy}, 0);
    chk("busy_ign_led", {24'b0, sl_led}, 8'h5A);
    chk("busy_ign_ack_err", {31'b0, ack_err}, 0);
    repeat (5) tick();

    // Reset inside WR_DATA (which begins 40*CLK_DIV cycles after acceptance)
    launch(7'h55, 1'b0, 8'h0F);
    repeat (180) tick();
    chk("abort_busy_before", {31'b0, busy}, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_scl", {31'b0, scl}, 1);
    chk("abort_sda", {31'b0, sda_s}, 1);
    chk("abort_busy", {31'b0, busy}, 0);
    chk("abort_done", {31'b0, done}, 0);
    repeat (10) tick();
    chk("abort_done_late", {31'b0, done}, 0);
    chk("abort_led", {24'b0, sl_led}, 8'h5A);
    launch(7'h55, 1'b0, 8'hC3);
    wait_done(1000, dt);
    chk("post_abort_cycle", dt, 80 * D1);
    chk("post_abort_ack_err", {31'b0, ack_err}, 0);
    chk("post_abort_led", {24'b0, sl_led}, 8'hC3);
    frame_edges("post_abort");
    repeat (5) tick();

    // CLK_DIV=250 instance on an empty bus: address NACK
    addr   = 7'h12;
    rw     = 1'b0;
    tx     = 8'h00;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    chk("d250_busy", {31'b0, busy2}, 1);
    dt = 0;
    while (!done2 && dt < 12000) begin
      tick();
      dt++;
    end
    chk("d250_done_cycle", dt, 44 * D2);
    chk("d250_ack_err", {31'b0, ack2}, 1);
    chk("d250_rx", {24'b0, rx2}, 8'h00);
    tick();
    chk("d250_idle", {30'b0, busy2, scl2}, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
